// File: rtl/concatenador_secuencial_if.sv
// Fragment-in / word-out bus of the sequential concatenator.
// The master drives fragments and abort; the slave returns the assembled word and occupancy.
interface concatenador_secuencial_if #(
    parameter int ANCHO  = 1,
    parameter int PARTES = 2
);
    localparam int CW = (PARTES > 2) ? $clog2(PARTES) : 1;

    logic [ANCHO-1:0]        dato_in;
    logic                    valido_in;
    logic                    limpiar;
    logic [PARTES*ANCHO-1:0] salida;
    logic                    valido_out;
    logic [CW-1:0]           cuenta;
    logic                    ocupado;

    modport master (
        output dato_in, valido_in, limpiar,
        input  salida, valido_out, cuenta, ocupado
    );

    modport slave (
        input  dato_in, valido_in, limpiar,
        output salida, valido_out, cuenta, ocupado
    );
endinterface

// File: rtl/concatenador_secuencial.sv
// Packs PARTES fragments of ANCHO bits into one registered word, one fragment per cycle.
// salida only changes on completion or reset; limpiar aborts the word in progress.
module concatenador_secuencial #(
    parameter int ANCHO       = 1,
    parameter int PARTES      = 2,
    parameter int MSB_PRIMERO = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    concatenador_secuencial_if.slave bus
);
    localparam int W  = PARTES * ANCHO;
    localparam int CW = (PARTES > 2) ? $clog2(PARTES) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PARTES - 1);

    logic [W-1:0]  parcial;
    logic [W-1:0]  palabra;
    logic [W-1:0]  salida_q;
    logic          valido_q;
    logic [CW-1:0] cuenta_q;

    // Partial word with the incoming fragment dropped into its slot
    always_comb begin
        palabra = parcial;
        for (int k = 0; k < PARTES; k++) begin
            if (cuenta_q == CW'(k)) begin
                palabra[((MSB_PRIMERO != 0) ? (PARTES - 1 - k) : k) * ANCHO +: ANCHO] = bus.dato_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parcial  <= '0;
            salida_q <= '0;
            valido_q <= 1'b0;
            cuenta_q <= '0;
        end else begin
            valido_q <= 1'b0;
            if (bus.limpiar) begin
                parcial  <= '0;
                cuenta_q <= '0;
            end else if (bus.valido_in) begin
                if (cuenta_q == ULTIMO) begin
                    salida_q <= palabra;
                    valido_q <= 1'b1;
                    parcial  <= '0;
                    cuenta_q <= '0;
                end else begin
                    parcial  <= palabra;
                    cuenta_q <= cuenta_q + 1'b1;
                end
            end
        end
    end

    assign bus.salida     = salida_q;
    assign bus.valido_out = valido_q;
    assign bus.cuenta     = cuenta_q;
    assign bus.ocupado    = (cuenta_q != '0);
endmodule

// File: tb/tb_concatenador_secuencial.sv
// Three concatenator configurations driven by one fragment stream; a scoreboard of
// expected words is checked by a negedge monitor alongside count/occupancy/hold checks.
module tb_concatenador_secuencial;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    concatenador_secuencial_if #(.ANCHO(4), .PARTES(3)) ia ();
    concatenador_secuencial_if #(.ANCHO(4), .PARTES(3)) ib ();
    concatenador_secuencial_if #(.ANCHO(1), .PARTES(2)) ic ();

    concatenador_secuencial #(.ANCHO(4), .PARTES(3), .MSB_PRIMERO(0)) ua (.clk(clk), .reset(reset), .bus(ia));
    concatenador_secuencial #(.ANCHO(4), .PARTES(3), .MSB_PRIMERO(1)) ub (.clk(clk), .reset(reset), .bus(ib));
    concatenador_secuencial ucd (.clk(clk), .reset(reset), .bus(ic));

    int total = 0;
    int bad = 0;
    bit armed = 0;

    int cfg_a[3] = '{4, 4, 1};
    int cfg_p[3] = '{3, 3, 2};
    int cfg_m[3] = '{0, 1, 0};

    int          nfrag[3];
    logic [3:0]  frags[3][3];
    logic [11:0] last[3];
    logic        exp_pulse[3];
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] q2[$];

    task automatic push_exp(input int i, input logic [11:0] w);
        case (i)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic model_edge(input logic [3:0] d, input logic v, input logic l, input logic r);
        for (int i = 0; i < 3; i++) begin
            exp_pulse[i] = 1'b0;
            if (r) begin
                nfrag[i] = 0;
                last[i]  = '0;
            end else if (l) begin
                nfrag[i] = 0;
            end else if (v) begin
                frags[i][nfrag[i]] = d & 4'((1 << cfg_a[i]) - 1);
                nfrag[i]++;
                if (nfrag[i] == cfg_p[i]) begin
                    logic [11:0] w;
                    w = '0;
                    for (int k = 0; k < cfg_p[i]; k++) begin
                        int pos;
                        pos = (cfg_m[i] != 0) ? (cfg_p[i] - 1 - k) : k;
                        w = w | (12'(frags[i][k]) << (pos * cfg_a[i]));
                    end
                    last[i] = w;
                    exp_pulse[i] = 1'b1;
                    push_exp(i, w);
                    nfrag[i] = 0;
                end
            end
        end
        if (r) armed = 1;
    endtask

    task automatic step(input logic [3:0] d, input logic v, input logic l, input logic r);
        ia.dato_in = d;    ib.dato_in = d;    ic.dato_in = d[0];
        ia.valido_in = v;  ib.valido_in = v;  ic.valido_in = v;
        ia.limpiar = l;    ib.limpiar = l;    ic.limpiar = l;
        reset = r;
        @(posedge clk);
        model_edge(d, v, l, r);
        #1;
    endtask

    task automatic chk(input int i, input logic vo, input logic [11:0] sal, input int cu, input logic oc);
        logic [11:0] e;
        bit have;
        total++;
        if (vo !== exp_pulse[i]) begin
            bad++;
            $display("FAIL pulse[%0d] t=%0t got=%b want=%b", i, $time, vo, exp_pulse[i]);
        end
        total++;
        if (sal !== last[i]) begin
            bad++;
            $display("FAIL salida[%0d] t=%0t got=%h want=%h", i, $time, sal, last[i]);
        end
        total++;
        if (cu != nfrag[i] || oc !== (nfrag[i] != 0)) begin
            bad++;
            $display("FAIL cuenta[%0d] t=%0t got=%0d/%b want=%0d/%b", i, $time, cu, oc, nfrag[i], nfrag[i] != 0);
        end
        if (vo === 1'b1) begin
            have = 0;
            e = '0;
            case (i)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
            endcase
            total++;
            if (!have) begin
                bad++;
                $display("FAIL word[%0d] t=%0t got=%h want=none", i, $time, sal);
            end else if (sal !== e) begin
                bad++;
                $display("FAIL word[%0d] t=%0t got=%h want=%h", i, $time, sal, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk(0, ia.valido_out, ia.salida, int'(ia.cuenta), ia.ocupado);
            chk(1, ib.valido_out, ib.salida, int'(ib.cuenta), ib.ocupado);
            chk(2, ic.valido_out, {10'b0, ic.salida}, int'(ic.cuenta), ic.ocupado);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            nfrag[i] = 0;
            last[i] = '0;
            exp_pulse[i] = 1'b0;
        end
        step(4'h0, 1'b1, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h1, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        // realign then A,B,C with gaps
        step(4'h0, 1'b0, 1'b1, 1'b0);
        step(4'hA, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'hB, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'hC, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) step(4'(k), 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'hA, 1'b1, 1'b0, 1'b0);
        step(4'hB, 1'b1, 1'b0, 1'b0);
        step(4'hC, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) step(4'(k), 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h7, 1'b1, 1'b0, 1'b0);
        step(4'h8, 1'b1, 1'b0, 1'b0);
        step(4'h9, 1'b1, 1'b0, 1'b1);
        step(4'h4, 1'b1, 1'b0, 1'b0);
        step(4'h5, 1'b1, 1'b0, 1'b0);
        step(4'h6, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            step(4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0);
        end
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            bad++;
            $display("FAIL missing_words got=%0d/%0d/%0d want=0/0/0", q0.size(), q1.size(), q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/concatenador_secuencial.md
CONCATENADOR_SECUENCIAL -- requirements
Module: concatenador_secuencial

Interface
REQ-001 The block SHALL have parameter ANCHO, default 1, giving the width of each input fragment in bits (ANCHO >= 1).
REQ-002 The block SHALL have parameter PARTES, default 2, giving the number of fragments per output word (PARTES >= 2).
REQ-003 The block SHALL have parameter MSB_PRIMERO, default 0: 0 = first fragment lands in salida[ANCHO-1:0]; 1 = first fragment lands in the top ANCHO bits.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 dato_in  input  ANCHO  fragment to append.
REQ-008 valido_in  input  1  dato_in is sampled on a rising edge where valido_in=1.
REQ-009 limpiar  input  1  synchronous abort of the word in progress.
REQ-010 salida  output  PARTES*ANCHO  last completed word, registered.
REQ-011 valido_out  output  1  one-cycle pulse: salida has just been updated.
REQ-012 cuenta  output  CW  fragments held in the partial word; CW = max(1, clog2(PARTES)).
REQ-013 ocupado  output  1  high when cuenta != 0.

Function
REQ-014 The block SHALL accept one fragment per cycle with no backpressure; every edge with valido_in=1 and limpiar=0 SHALL accept dato_in.
REQ-015 Fragment k (k = 0 first) SHALL occupy bits [k*ANCHO +: ANCHO] when MSB_PRIMERO=0, and bits [(PARTES-1-k)*ANCHO +: ANCHO] when MSB_PRIMERO=1.
REQ-016 Each accepted fragment SHALL increment cuenta by 1, except that acceptance at cuenta = PARTES-1 SHALL return cuenta to 0 (wrap).
REQ-017 On acceptance at cuenta = PARTES-1, the completed word (partial word plus the current fragment) SHALL be loaded into salida at that same edge, and valido_out SHALL be 1 for exactly the following cycle (latency: one edge from the last fragment).
REQ-018 salida SHALL hold its value between completions; partial fragments SHALL NOT be visible on salida.
REQ-019 Back-to-back words SHALL be supported: a fragment accepted in the cycle after completion starts a new word at k=0 with no dead cycle.
REQ-020 valido_out SHALL pulse once per completed word, including consecutive completions when PARTES fragments arrive in consecutive cycles.
REQ-021 Cycles with valido_in=0 SHALL leave cuenta and the partial word unchanged (gaps are allowed anywhere in a word).
REQ-022 limpiar=1 SHALL set cuenta to 0 and discard the partial word; salida SHALL be unchanged and valido_out SHALL be 0 in the next cycle.
REQ-023 limpiar=1 together with valido_in=1 SHALL discard dato_in (limpiar has priority), even at cuenta = PARTES-1.
REQ-024 ocupado SHALL be combinationally equal to (cuenta != 0).
REQ-025 With ANCHO=1, PARTES=2, MSB_PRIMERO=0, a complete word SHALL equal {second, first}.

Reset
REQ-026 reset=1 at a rising edge SHALL force salida=0, valido_out=0, cuenta=0 and clear the partial word, with priority over limpiar and valido_in.
REQ-027 reset asserted mid-word SHALL discard the partial word; the first fragment after reset is released SHALL be k=0.
REQ-028 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour is permitted.

Verification
REQ-029 Defaults; reset, then fragments 1 then 0 in consecutive cycles -> salida=2'b01 and valido_out=1 for one cycle after the second edge; cuenta 0->1->0.
REQ-030 ANCHO=4, PARTES=3, MSB_PRIMERO=0; fragments 0xA,0xB,0xC with idle cycles between them -> salida=12'hCBA, a single valido_out pulse, cuenta holds during gaps.
REQ-031 Same configuration with MSB_PRIMERO=1 -> salida=12'hABC.
REQ-032 ANCHO=4, PARTES=3; six fragments 1..6 in consecutive cycles -> salida=12'h321, then 12'h654; valido_out pulses in the cycle after the 3rd and 6th edges.
REQ-033 ANCHO=4, PARTES=3; 0xA, 0xB, then limpiar=1 with valido_in=1 and 0xC, then 0x1,0x2,0x3 -> no pulse from the aborted word; salida=12'h321.
REQ-034 Reset asserted at cuenta=2 together with valido_in=1 -> salida=0, cuenta=0, no valido_out pulse; the next three fragments form a full word.
